mdr_mem_if: RTL and testbench
=============================

# mdr_mem_if

Parametrised memory data register with a built-in memory handshake engine, the successor to the plain MDR in the datapath. It holds a DATA_WIDTH operand loaded from the bus or from memory. It runs read and write transactions against a slave with a req/ready handshake, and supports byte, half and word access with lane selection, sign or zero extension, write-lane replication and a timeout. It sits between the internal bus, the control unit (which stalls on `busy`) and the memory port.

## Interface
- DATA_WIDTH, 32: register/bus width; power of two, ≥32.
- INIT, 0: MDR value after `clear`.
- TIMEOUT, 16: cycles to wait for `mem_ready` before abort; 0 disables timeout.
- LANE_W, $clog2(DATA_WIDTH/8): byte-offset width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  reset, asynchronous, active-high
- mdrin  in  1  load MDR from BusMuxOut
- BusMuxOut  in  DATA_WIDTH  bus data
- read  in  1  start memory read
- write  in  1  start memory write
- size  in  2  00 byte, 01 half, 10 word (32 b), 11 full DATA_WIDTH
- sign_ext  in  1  sign-extend narrow reads (else zero-extend)
- addr_lo  in  LANE_W  byte offset within memory word
- mem_req  out  1  transaction request
- mem_we  out  1  1 = write
- mem_be  out  DATA_WIDTH/8  byte enables
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data
- mem_ready  in  1  slave completion
- MDROut  out  DATA_WIDTH  register contents
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky misalign/timeout flag

## Operation
- States: IDLE, READ, WRITE. All are registered; `busy` is decoded from the state.
- **IDLE**
  - `mdrin`=1 loads BusMuxOut into MDR.
  - `read`=1 (priority over `write`) or `write`=1 latches size, sign_ext and addr_lo, and clears `error`.
  - If the access is misaligned (half at an odd offset; word at offset not ≡0 mod 4; full at offset ≠0): no request is issued, `error` is set and `done` pulses. State stays IDLE.
  - If aligned: the block enters READ or WRITE.
- **READ**
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_be` = the selected lanes.
  - On an edge with `mem_ready`=1: the selected lanes of `mem_rdata` are right-aligned, then extended per sign_ext, then loaded into MDR. State returns to IDLE and `done`=1.
- **WRITE**
  - Outputs: `mem_req`=1, `mem_we`=1, `mem_be` = the selected lanes.
  - `mem_wdata`: MDR low byte replicated into every byte (byte access), low half replicated into every half (half access), low word replicated into every word (word access), or MDR as-is (full access).
  - On `mem_ready`=1: return to IDLE and `done`=1. MDR is unchanged.
- **Timeout:** a counter runs in READ/WRITE. When it reaches TIMEOUT without `mem_ready`: abort to IDLE, set `error`, pulse `done`, leave MDR unchanged.
- **While busy:** `mdrin`, `read` and `write` are ignored, not queued.
- **`mdrin` with `read` in IDLE:** both take effect; the read result later overwrites MDR.
- **`mdrin` with `write` in IDLE:** the write drives the newly loaded value.
- **Outside READ/WRITE:** `mem_rdata` and `mem_ready` are ignored, and `mem_be`, `mem_req` and `mem_we` are 0.

## Timing
- **Reset:** `clear` asynchronously forces state=IDLE, MDR=INIT, mem_req=0, mem_we=0, mem_be=0, done=0, error=0 and counter=0. This includes reset mid-transaction; the request drops immediately.
- `read`/`write` sampled at edge E0 → `mem_req` high from E0. `mem_ready` sampled at Ek (k≥1) → MDROut valid, `mem_req` low and `done` high from Ek, for one cycle.
- Minimum transaction is 2 edges; a zero-wait slave gives `busy` high for exactly 1 cycle.
- Misalignment: `done` and `error` are high from E0.
- Timeout: abort at E0+TIMEOUT.
- `mem_req`, `mem_we`, `mem_be` and `mem_wdata` are stable for the whole request.

## Structure
- Package `mdr_pkg`: `size_t` enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_FULL) and `mdr_state_t` (IDLE, READ, WRITE).
- One combinational sub-module `mdr_lane_align`. It is parametrised by DATA_WIDTH and produces byte enables, misalign detection, read extract/extend and write replication.
- The top level holds the FSM, MDR, timeout counter and the done/error flags.

## Test plan
- **Reset:** INIT=32'hDEADBEEF, assert `clear` mid-READ → MDROut=DEADBEEF, mem_req=0 and busy=0 immediately, without a clock edge.
- **Signed byte read:** size=00, sign_ext=1, addr_lo=2, mem_rdata=32'h1280_3456, ready after 3 cycles → MDROut=FFFFFF80, mem_be=4'b0100, done for 1 cycle, busy 3 cycles.
- **Half write:** mdrin with BusMuxOut=32'hAAAA_BEEF plus write, size=01, addr_lo=2, same edge → mem_wdata=BEEFBEEF, mem_be=4'b1100, mem_we=1; MDR unchanged after done.
- **Misalign:** word read at addr_lo=1 → no mem_req, error=1, done at E0. A following aligned read clears error.
- **Timeout:** TIMEOUT=4, mem_ready held 0 → abort after 4 cycles, error=1, MDR unchanged.
- **Width and conflicts:** DATA_WIDTH=64, size=11, read with zero-wait ready → full 64-bit load. Read and write together issue a read. Requests arriving while busy are ignored.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types for the memory data register: access sizes and FSM states.
package mdr_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } mdr_state_t;

  // Number of bytes touched by an access of the given size.
  function automatic int size_bytes(input size_t sz, input int nb);
    case (sz)
      SZ_BYTE: size_bytes = 1;
      SZ_HALF: size_bytes = 2;
      SZ_WORD: size_bytes = 4;
      default: size_bytes = nb;
    endcase
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Byte-lane steering for the MDR: byte enables, misalignment detection,
// read extract/extend and write-data replication. Purely combinational.
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int LANE_W     = $clog2(NB)
) (
  input  size_t                 size,
  input  logic                  sign_ext,
  input  logic [LANE_W-1:0]     addr_lo,
  input  logic [DATA_WIDTH-1:0] mdr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [NB-1:0]         be,
  output logic                  misalign,
  output logic [DATA_WIDTH-1:0] rdata_ext,
  output logic [DATA_WIDTH-1:0] wdata
);

  logic [DATA_WIDTH-1:0] sh;
  logic                  fill;
  int                    nbytes;
  int                    lo;

  // Right-align the addressed lanes so the low bits hold the operand.
  assign sh = rdata >> {addr_lo, 3'b000};

  // Size decode: lane count, alignment rule and the sign bit of the operand.
  always_comb begin
    nbytes   = size_bytes(size, NB);
    lo       = int'(addr_lo);
    misalign = 1'b0;
    fill     = 1'b0;
    case (size)
      SZ_BYTE: fill = sh[7];
      SZ_HALF: begin misalign = addr_lo[0];    fill = sh[15]; end
      SZ_WORD: begin misalign = |addr_lo[1:0]; fill = sh[31]; end
      default: misalign = |addr_lo;
    endcase
  end

  // Lane enables: a contiguous run of nbytes lanes starting at the offset.
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++)
      be[i] = (i >= lo) && (i < lo + nbytes);
  end

  // Keep the operand bits, fill the rest with sign or zero.
  always_comb begin
    rdata_ext = sh;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i >= nbytes * 8) rdata_ext[i] = sign_ext & fill;
  end

  // Replicate the low operand across the bus so any lane choice sees it.
  always_comb begin
    case (size)
      SZ_BYTE: wdata = {NB{mdr[7:0]}};
      SZ_HALF: wdata = {(NB/2){mdr[15:0]}};
      SZ_WORD: wdata = {(NB/4){mdr[31:0]}};
      default: wdata = mdr;
    endcase
  end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with a req/ready handshake engine. Holds one bus-wide
// operand, runs single read/write transactions with lane selection, and
// aborts on misalignment or slave timeout.
module mdr_mem_if
  import mdr_pkg::*;
#(
  parameter  int                    DATA_WIDTH = 32,
  parameter  logic [DATA_WIDTH-1:0] INIT       = '0,
  parameter  int                    TIMEOUT    = 16,
  localparam int                    LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    mdrin,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  input  logic                    read,
  input  logic                    write,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [LANE_W-1:0]       addr_lo,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   MDROut,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mdr_state_t             state;
  logic [DATA_WIDTH-1:0]  mdr;
  logic [CW-1:0]          cnt;
  size_t                  lat_size;
  logic                   lat_sext;
  logic [LANE_W-1:0]      lat_lo;

  logic                   idle;
  size_t                  acc_size;
  logic                   acc_sext;
  logic [LANE_W-1:0]      acc_lo;
  logic [DATA_WIDTH/8-1:0] be;
  logic                   misalign;
  logic [DATA_WIDTH-1:0]  rdata_ext;
  logic [DATA_WIDTH-1:0]  wdata;

  // In IDLE the aligner checks the incoming request; afterwards it works
  // from the latched attributes so outputs hold for the whole request.
  assign idle     = (state == IDLE);
  assign acc_size = idle ? size_t'(size) : lat_size;
  assign acc_sext = idle ? sign_ext : lat_sext;
  assign acc_lo   = idle ? addr_lo  : lat_lo;

  mdr_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size      (acc_size),
    .sign_ext  (acc_sext),
    .addr_lo   (acc_lo),
    .mdr       (mdr),
    .rdata     (mem_rdata),
    .be        (be),
    .misalign  (misalign),
    .rdata_ext (rdata_ext),
    .wdata     (wdata)
  );

  assign busy      = !idle;
  assign mem_req   = (state == READ) || (state == WRITE);
  assign mem_we    = (state == WRITE);
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = wdata;
  assign MDROut    = mdr;

  // Transaction FSM with timeout counter and done/error flags.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      lat_size <= SZ_BYTE;
      lat_sext <= 1'b0;
      lat_lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (read || write) begin
            lat_size <= size_t'(size);
            lat_sext <= sign_ext;
            lat_lo   <= addr_lo;
            cnt      <= '0;
            error    <= misalign;
            if (misalign) done  <= 1'b1;
            else          state <= read ? READ : WRITE;
          end
        end
        READ, WRITE: begin
          if (mem_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MDR: bus load only when idle; read data lands on the completing edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                         mdr <= INIT;
    else if (idle && mdrin)            mdr <= BusMuxOut;
    else if (state == READ && mem_ready) mdr <= rdata_ext;
  end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed bench for mdr_mem_if: a 32-bit instance (INIT=DEADBEEF, TIMEOUT=4)
// and a 64-bit instance share clock and clear.
module tb_mdr_mem_if;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // 32-bit instance
  logic        a_mdrin, a_read, a_write, a_sext, a_ready;
  logic [31:0] a_bus, a_rdata, a_wdata, a_mdr;
  logic [1:0]  a_size, a_lo;
  logic        a_req, a_we, a_busy, a_done, a_err;
  logic [3:0]  a_be;

  mdr_mem_if #(.DATA_WIDTH(32), .INIT(32'hDEADBEEF), .TIMEOUT(4)) dut_a (
    .clock(clock), .clear(clear), .mdrin(a_mdrin), .BusMuxOut(a_bus),
    .read(a_read), .write(a_write), .size(a_size), .sign_ext(a_sext),
    .addr_lo(a_lo), .mem_req(a_req), .mem_we(a_we), .mem_be(a_be),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
    .MDROut(a_mdr), .busy(a_busy), .done(a_done), .error(a_err)
  );

  // 64-bit instance
  logic        b_mdrin, b_read, b_write, b_sext, b_ready;
  logic [63:0] b_bus, b_rdata, b_wdata, b_mdr;
  logic [1:0]  b_size;
  logic [2:0]  b_lo;
  logic        b_req, b_we, b_busy, b_done, b_err;
  logic [7:0]  b_be;

  mdr_mem_if #(.DATA_WIDTH(64)) dut_b (
    .clock(clock), .clear(clear), .mdrin(b_mdrin), .BusMuxOut(b_bus),
    .read(b_read), .write(b_write), .size(b_size), .sign_ext(b_sext),
    .addr_lo(b_lo), .mem_req(b_req), .mem_we(b_we), .mem_be(b_be),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
    .MDROut(b_mdr), .busy(b_busy), .done(b_done), .error(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    a_mdrin = 0; a_read = 0; a_write = 0; a_sext = 0; a_ready = 0;
    a_bus = '0; a_rdata = '0; a_size = 2'b00; a_lo = '0;
    b_mdrin = 0; b_read = 0; b_write = 0; b_sext = 0; b_ready = 0;
    b_bus = '0; b_rdata = '0; b_size = 2'b00; b_lo = '0;
    #1;
    chk("rst_mdr",  a_mdr,  32'hDEADBEEF);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_req",  a_req,  1'b0);
    chk("rst_be",   a_be,   4'b0000);
    chk("rst_done", a_done, 1'b0);
    chk("rst_err",  a_err,  1'b0);
    chk("rst_mdr64", b_mdr, 64'h0);
    tick(); clear = 1'b0;
    tick();

    // signed byte read, lane 2, ready on the third edge after start
    a_read = 1; a_size = 2'b00; a_sext = 1; a_lo = 2'd2; a_rdata = 32'h1280_3456;
    tick(); a_read = 0;
    chk("sb_busy0", a_busy, 1'b1);
    chk("sb_req",   a_req,  1'b1);
    chk("sb_we",    a_we,   1'b0);
    chk("sb_be",    a_be,   4'b0100);
    chk("sb_done0", a_done, 1'b0);
    tick();
    chk("sb_busy1", a_busy, 1'b1);
    tick();
    chk("sb_busy2", a_busy, 1'b1);
    a_ready = 1;
    tick(); a_ready = 0;
    chk("sb_mdr",   a_mdr,  32'hFFFF_FF80);
    chk("sb_done",  a_done, 1'b1);
    chk("sb_idle",  a_busy, 1'b0);
    chk("sb_reqlo", a_req,  1'b0);
    chk("sb_belo",  a_be,   4'b0000);
    tick();
    chk("sb_done1cyc", a_done, 1'b0);

    // bus load and half write at offset 2 on the same edge
    a_mdrin = 1; a_bus = 32'hAAAA_BEEF; a_write = 1; a_size = 2'b01; a_lo = 2'd2; a_sext = 0;
    tick(); a_mdrin = 0; a_write = 0;
    chk("hw_mdr",   a_mdr,   32'hAAAA_BEEF);
    chk("hw_wdata", a_wdata, 32'hBEEF_BEEF);
    chk("hw_be",    a_be,    4'b1100);
    chk("hw_we",    a_we,    1'b1);
    chk("hw_req",   a_req,   1'b1);
    a_ready = 1;
    tick(); a_ready = 0;
    chk("hw_done",  a_done, 1'b1);
    chk("hw_mdr2",  a_mdr,  32'hAAAA_BEEF);
    chk("hw_err",   a_err,  1'b0);

    // misaligned word read
    a_read = 1; a_size = 2'b10; a_lo = 2'd1;
    tick(); a_read = 0;
    chk("mis_req",  a_req,  1'b0);
    chk("mis_busy", a_busy, 1'b0);
    chk("mis_err",  a_err,  1'b1);
    chk("mis_done", a_done, 1'b1);
    tick();
    chk("mis_done1cyc", a_done, 1'b0);
    chk("mis_sticky",   a_err,  1'b1);
    // aligned read clears error
    a_read = 1; a_size = 2'b10; a_lo = 2'd0; a_rdata = 32'hCAFE_F00D;
    tick(); a_read = 0;
    chk("al_errclr", a_err,  1'b0);
    chk("al_be",     a_be,   4'b1111);
    chk("al_busy",   a_busy, 1'b1);
    a_ready = 1;
    tick(); a_ready = 0;
    chk("al_mdr",  a_mdr,  32'hCAFE_F00D);
    chk("al_done", a_done, 1'b1);

    // byte write to lane 3, slave never answers -> timeout at E0+4
    a_write = 1; a_size = 2'b00; a_lo = 2'd3;
    tick(); a_write = 0;
    chk("to_wdata", a_wdata, 32'h0D0D_0D0D);
    chk("to_be",    a_be,    4'b1000);
    chk("to_we",    a_we,    1'b1);
    tick(); tick(); tick();
    chk("to_busy3", a_busy, 1'b1);
    chk("to_done3", a_done, 1'b0);
    tick();
    chk("to_busy4", a_busy, 1'b0);
    chk("to_done",  a_done, 1'b1);
    chk("to_err",   a_err,  1'b1);
    chk("to_mdr",   a_mdr,  32'hCAFE_F00D);
    chk("to_req",   a_req,  1'b0);

    // read+write together -> read; requests while busy are dropped
    a_read = 1; a_write = 1; a_size = 2'b10; a_lo = 2'd0;
    tick(); a_read = 0; a_write = 0;
    chk("rw_we",  a_we,  1'b0);
    chk("rw_req", a_req, 1'b1);
    chk("rw_err", a_err, 1'b0);
    a_write = 1; a_mdrin = 1; a_bus = 32'h1111_1111;
    tick(); a_write = 0; a_mdrin = 0;
    chk("bz_busy", a_busy, 1'b1);
    chk("bz_we",   a_we,   1'b0);
    chk("bz_mdr",  a_mdr,  32'hCAFE_F00D);
    a_rdata = 32'h0BAD_C0DE; a_ready = 1;
    tick(); a_ready = 0;
    chk("rw_mdr",  a_mdr,  32'h0BAD_C0DE);
    chk("rw_done", a_done, 1'b1);
    tick();
    chk("bz_noq_busy", a_busy, 1'b0);
    chk("bz_noq_req",  a_req,  1'b0);

    // zero-wait zero-extended byte read: busy for exactly one cycle
    a_ready = 1; a_rdata = 32'h1280_3456;
    a_read = 1; a_size = 2'b00; a_sext = 0; a_lo = 2'd2;
    tick(); a_read = 0;
    chk("zw_busy", a_busy, 1'b1);
    tick(); a_ready = 0;
    chk("zw_idle", a_busy, 1'b0);
    chk("zw_done", a_done, 1'b1);
    chk("zw_mdr",  a_mdr,  32'h0000_0080);

    // 64-bit: full-width zero-wait read
    b_read = 1; b_size = 2'b11; b_lo = 3'd0; b_rdata = 64'h0123_4567_89AB_CDEF; b_ready = 1;
    tick(); b_read = 0;
    chk("w64_be",   b_be,   8'hFF);
    chk("w64_busy", b_busy, 1'b1);
    tick(); b_ready = 0;
    chk("w64_mdr",  b_mdr,  64'h0123_4567_89AB_CDEF);
    chk("w64_done", b_done, 1'b1);
    chk("w64_idle", b_busy, 1'b0);
    // 64-bit: word write to upper word replicates low word
    b_mdrin = 1; b_bus = 64'hFFFF_0000_1122_3344; b_write = 1; b_size = 2'b10; b_lo = 3'd4;
    tick(); b_mdrin = 0; b_write = 0;
    chk("w64_wdata", b_wdata, 64'h1122_3344_1122_3344);
    chk("w64_wbe",   b_be,    8'hF0);
    chk("w64_we",    b_we,    1'b1);
    b_ready = 1;
    tick(); b_ready = 0;
    chk("w64_wdone", b_done, 1'b1);
    chk("w64_wmdr",  b_mdr,  64'hFFFF_0000_1122_3344);

    // asynchronous clear in the middle of a read
    a_read = 1; a_size = 2'b10; a_lo = 2'd0;
    tick(); a_read = 0;
    chk("ar_busy", a_busy, 1'b1);
    #2 clear = 1'b1;
    #1;
    chk("ar_mdr",  a_mdr,  32'hDEADBEEF);
    chk("ar_req",  a_req,  1'b0);
    chk("ar_busy0", a_busy, 1'b0);
    chk("ar_mdr64", b_mdr, 64'h0);
    tick(); clear = 1'b0;
    tick();
    chk("ar_stay", a_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
